priority_encoder_scan: RTL and testbench

- Sequential N-to-log2(N) priority encoder: the inverse of the team's 2-to-4 one-hot decoder.
- Captures a multi-hot request vector and emits the binary index of every set bit, one per handshake, highest index first.
- Sits between request-line sources and any consumer that takes binary codes, e.g. a decoder that drives a one-hot select.
- Completion is signalled once all captured bits are drained.

---
 rtl/priority_encoder_scan.sv | 109 ++++++++++
 tb/tb_priority_encoder_scan.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/priority_encoder_scan.sv
// Sequential priority encoder: captures a multi-hot request vector on LOAD and
// emits the binary index of each set bit, highest first, one per VALID/READY
// handshake. DONE pulses for one cycle when the scan drains or a zero vector
// is loaded.
//
// Ports:
//   CLK    - clock, rising-edge
//   RST_N  - synchronous active-low reset
//   I      - request vector, sampled on an accepted LOAD
//   LOAD   - capture strobe, accepted only while idle
//   BUSY   - captured requests remain to be emitted
//   A      - code of the highest pending bit (0 while VALID=0)
//   VALID  - A holds a code
//   READY  - consumer accepts A on VALID && READY
//   DONE   - one-cycle completion pulse
module priority_encoder_scan #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [N-1:0] I,
  input  logic         LOAD,
  output logic         BUSY,
  output logic [W-1:0] A,
  output logic         VALID,
  input  logic         READY,
  output logic         DONE
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] code_q, code_d;
  logic         done_q, done_d;
  logic [N-1:0] cleared;

  // Index of the highest set bit of a vector (0 for an all-zero vector).
  function automatic logic [W-1:0] highest_index(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (v[i]) idx = W'(i);
    end
    return idx;
  endfunction

  // Pending vector with the currently presented code removed.
  assign cleared = pending_q & ~(N'(1) << code_q);

  // Next-state, next-pending and next-code logic.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    code_d    = '0;

    unique case (state_q)
      IDLE: begin
        if (LOAD) begin
          if (I != '0) begin
            pending_d = I;
            state_d   = SCAN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (READY) begin
          pending_d = cleared;
          if (cleared == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The code is precomputed so A comes straight from a register.
    if (state_d == SCAN) code_d = highest_index(pending_d);
  end

  // State registers; reset wins over LOAD and READY and suppresses DONE.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      pending_q <= '0;
      code_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      done_q    <= done_d;
    end
  end

  assign BUSY  = (state_q == SCAN);
  assign VALID = (state_q == SCAN);
  assign A     = code_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_priority_encoder_scan.sv
// Bench for priority_encoder_scan: directed scenarios plus random traffic,
// all checked cycle by cycle against a queue-based reference model.
module tb_priority_encoder_scan;

  localparam int unsigned N = 4;
  localparam int unsigned W = 2;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] i_vec;
  logic         load;
  logic         busy;
  logic [W-1:0] a;
  logic         valid;
  logic         ready;
  logic         done;

  int checks;
  int failures;

  // Reference model: codes still to be emitted, front is the one on A.
  int exp_q[$];
  bit exp_done;

  priority_encoder_scan #(.N(N), .W(W)) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .I    (i_vec),
    .LOAD (load),
    .BUSY (busy),
    .A    (a),
    .VALID(valid),
    .READY(ready),
    .DONE (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Model of one rising edge with the given inputs.
  task automatic model_edge(input logic r_n, input logic ld, input logic [N-1:0] v,
                            input logic rdy);
    exp_done = 1'b0;
    if (!r_n) begin
      exp_q.delete();
    end else if (exp_q.size() > 0) begin
      if (rdy) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) exp_done = 1'b1;
      end
    end else if (ld) begin
      if (v == '0) exp_done = 1'b1;
      for (int k = N - 1; k >= 0; k--) begin
        if (v[k]) exp_q.push_back(k);
      end
    end
  endtask

  // Drive inputs, clock once, update the model, then compare all outputs.
  task automatic step(input logic r_n, input logic ld, input logic [N-1:0] v,
                      input logic rdy);
    int exp_valid;
    int exp_a;
    rst_n = r_n;
    load  = ld;
    i_vec = v;
    ready = rdy;
    @(posedge clk);
    model_edge(r_n, ld, v, rdy);
    #1;
    exp_valid = (exp_q.size() > 0) ? 1 : 0;
    exp_a     = (exp_q.size() > 0) ? exp_q[0] : 0;
    check_eq("valid", int'(valid), exp_valid);
    check_eq("busy",  int'(busy),  exp_valid);
    check_eq("a",     int'(a),     exp_a);
    check_eq("done",  int'(done),  int'(exp_done));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_done = 1'b0;
    rst_n = 1'b0;
    load  = 1'b0;
    i_vec = '0;
    ready = 1'b0;

    // Reset state
    step(1'b0, 1'b0, 4'b0000, 1'b0);
    step(1'b0, 1'b1, 4'b1111, 1'b1);
    check_eq("reset_a", int'(a), 0);

    // 1010 with READY held high: 3, 1, then DONE
    step(1'b1, 1'b1, 4'b1010, 1'b1);
    check_eq("p1_a3", int'(a), 3);
    step(1'b1, 1'b0, 4'b0000, 1'b1);
    check_eq("p1_a1", int'(a), 1);
    step(1'b1, 1'b0, 4'b0000, 1'b1);
    check_eq("p1_done", int'(done), 1);
    step(1'b1, 1'b0, 4'b0000, 1'b1);
    check_eq("p1_done_once", int'(done), 0);

    // 1111 back to back
    step(1'b1, 1'b1, 4'b1111, 1'b1);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 4'b0000, 1'b1);

    // 0101 with a 5-cycle stall
    step(1'b1, 1'b1, 4'b0101, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 4'b0000, 1'b0);
      check_eq("stall_a2", int'(a), 2);
    end
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 4'b0000, 1'b1);

    // LOAD ignored while busy
    step(1'b1, 1'b1, 4'b0011, 1'b0);
    step(1'b1, 1'b1, 4'b1000, 1'b0);
    check_eq("ign_a1", int'(a), 1);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 4'b0000, 1'b1);

    // Zero vector load
    step(1'b1, 1'b1, 4'b0000, 1'b1);
    check_eq("zero_done", int'(done), 1);
    step(1'b1, 1'b0, 4'b0000, 1'b1);

    // Reset mid-scan, then a fresh load
    step(1'b1, 1'b1, 4'b1100, 1'b1);
    step(1'b1, 1'b0, 4'b0000, 1'b1);
    step(1'b0, 1'b0, 4'b0000, 1'b1);
    step(1'b1, 1'b0, 4'b0000, 1'b1);
    step(1'b1, 1'b1, 4'b0001, 1'b1);
    check_eq("rst_new_valid", int'(valid), 1);
    step(1'b1, 1'b0, 4'b0000, 1'b1);
    check_eq("rst_new_done", int'(done), 1);

    // Load in the same cycle as DONE
    step(1'b1, 1'b1, 4'b0010, 1'b1);
    step(1'b1, 1'b1, 4'b0100, 1'b1);
    step(1'b1, 1'b0, 4'b0000, 1'b1);
    step(1'b1, 1'b0, 4'b0000, 1'b1);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 63) != 0),
           ($urandom_range(0, 2) == 0),
           N'($urandom),
           ($urandom_range(0, 1) == 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
